// File: rtl/pop_timing_config.sv
// POP pulse timing configuration: button-driven shadow edits of the pi/2 and
// free-precession lengths, transferred to the active copies at cycle boundaries.
module pop_timing_config #(
  parameter int unsigned WIDTH         = 16,
  parameter int unsigned PIE_DEFAULT   = 250,
  parameter int unsigned FREE_DEFAULT  = 2500,
  parameter int unsigned STEP          = 5,
  parameter int unsigned MIN_LEN       = 5,
  parameter int unsigned MAX_LEN       = 25000,
  parameter int unsigned REPEAT_DELAY  = 5000,
  parameter int unsigned REPEAT_PERIOD = 1000
) (
  input  logic             clk_2M5,
  input  logic             reset_n,
  input  logic             tick_100us,
  input  logic             load_defaults,
  input  logic             pieovertwo_plus,
  input  logic             pieovertwo_minus,
  input  logic             freeprecess_plus,
  input  logic             freeprecess_minus,
  input  logic             cycle_end,
  input  logic             timer_idle,
  output logic [WIDTH-1:0] pieovertwo_len,
  output logic [WIDTH-1:0] freeprecess_len,
  output logic             cfg_pending,
  output logic             cfg_load,
  output logic [1:0]       at_limit
);

  localparam int unsigned NCH   = 2;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned WW    = WIDTH + 1;
  localparam int unsigned NSYNC = 5;

  localparam logic [WIDTH-1:0] PIE_DEF_W  = WIDTH'(PIE_DEFAULT);
  localparam logic [WIDTH-1:0] FREE_DEF_W = WIDTH'(FREE_DEFAULT);
  localparam logic [WIDTH-1:0] MIN_W      = WIDTH'(MIN_LEN);
  localparam logic [WIDTH-1:0] MAX_W      = WIDTH'(MAX_LEN);
  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOLD,
    ST_REPEAT,
    ST_BLOCKED
  } state_e;

  logic [NSYNC-1:0] sync1_q, sync1_d, sync2_q, sync2_d;

  state_e           state_q [NCH];
  state_e           state_d [NCH];
  logic [CNT_W-1:0] cnt_q   [NCH];
  logic [CNT_W-1:0] cnt_d   [NCH];
  logic [NCH-1:0]   dir_q, dir_d;
  logic [WIDTH-1:0] shadow_q [NCH];
  logic [WIDTH-1:0] shadow_d [NCH];
  logic [WIDTH-1:0] active_q [NCH];
  logic [WIDTH-1:0] active_d [NCH];
  logic             cfg_pending_q, cfg_pending_d;
  logic             cfg_load_q, cfg_load_d;
  logic [NCH-1:0]   at_limit_q, at_limit_d;

  logic             ld_s;
  logic [NCH-1:0]   btn_plus, btn_minus;
  logic [NCH-1:0]   hold_btn, other_btn;
  logic [CNT_W-1:0] hold_lim [NCH];
  logic [NCH-1:0]   step_en, step_up;
  logic             xfer_c;

  // Saturating step, evaluated one bit wider than the length so plus cannot wrap
  function automatic logic [WIDTH-1:0] step_len(input logic [WIDTH-1:0] len,
                                                input logic up);
    logic [WW-1:0] wide;
    wide = WW'(len);
    if (up) begin
      wide = wide + WW'(STEP);
      if (wide > WW'(MAX_LEN)) wide = WW'(MAX_LEN);
    end else if (wide < WW'(MIN_LEN + STEP)) begin
      wide = WW'(MIN_LEN);
    end else begin
      wide = wide - WW'(STEP);
    end
    return WIDTH'(wide);
  endfunction

  // Channel 0 is pi/2, channel 1 is free precession
  assign ld_s      = sync2_q[4];
  assign btn_plus  = {sync2_q[1], sync2_q[3]};
  assign btn_minus = {sync2_q[0], sync2_q[2]};

  always_comb begin
    sync1_d    = {load_defaults, pieovertwo_plus, pieovertwo_minus,
                  freeprecess_plus, freeprecess_minus};
    sync2_d    = sync1_q;
    state_d    = state_q;
    cnt_d      = cnt_q;
    dir_d      = dir_q;
    shadow_d   = shadow_q;
    step_en    = '0;
    step_up    = '0;
    hold_btn   = '0;
    other_btn  = '0;

    for (int unsigned ch = 0; ch < NCH; ch++) begin
      hold_btn[ch]  = dir_q[ch] ? btn_plus[ch]  : btn_minus[ch];
      other_btn[ch] = dir_q[ch] ? btn_minus[ch] : btn_plus[ch];
      hold_lim[ch]  = (state_q[ch] == ST_HOLD) ? DELAY_LAST : PERIOD_LAST;

      if (ld_s) begin
        state_d[ch] = ST_BLOCKED;
        cnt_d[ch]   = '0;
      end else if (tick_100us) begin
        case (state_q[ch])
          ST_IDLE: begin
            if (btn_plus[ch] && btn_minus[ch]) begin
              state_d[ch] = ST_BLOCKED;
            end else if (btn_plus[ch] || btn_minus[ch]) begin
              step_en[ch] = 1'b1;
              step_up[ch] = btn_plus[ch];
              dir_d[ch]   = btn_plus[ch];
              cnt_d[ch]   = '0;
              state_d[ch] = ST_HOLD;
            end
          end
          ST_HOLD, ST_REPEAT: begin
            if (!hold_btn[ch]) begin
              state_d[ch] = ST_IDLE;
            end else if (other_btn[ch]) begin
              state_d[ch] = ST_BLOCKED;
            end else if (cnt_q[ch] == hold_lim[ch]) begin
              step_en[ch] = 1'b1;
              step_up[ch] = dir_q[ch];
              cnt_d[ch]   = '0;
              state_d[ch] = ST_REPEAT;
            end else begin
              cnt_d[ch] = cnt_q[ch] + CNT_W'(1);
            end
          end
          default: begin
            if (!btn_plus[ch] && !btn_minus[ch]) state_d[ch] = ST_IDLE;
          end
        endcase
      end

      if (ld_s) begin
        shadow_d[ch] = (ch == 0) ? PIE_DEF_W : FREE_DEF_W;
      end else if (step_en[ch]) begin
        shadow_d[ch] = step_len(shadow_q[ch], step_up[ch]);
      end
    end

    // Active copies take the pre-edge shadow, so a coincident step stays pending
    xfer_c   = cfg_pending_q && (cycle_end || timer_idle);
    active_d = active_q;
    if (xfer_c) active_d = shadow_q;

    cfg_pending_d = (shadow_d[0] != active_d[0]) || (shadow_d[1] != active_d[1]);
    cfg_load_d    = xfer_c;
    at_limit_d    = '0;
    for (int unsigned ch = 0; ch < NCH; ch++) begin
      at_limit_d[ch] = (shadow_d[ch] == MIN_W) || (shadow_d[ch] == MAX_W);
    end
  end

  always_ff @(posedge clk_2M5 or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q       <= '0;
      sync2_q       <= '0;
      dir_q         <= '0;
      cfg_pending_q <= 1'b0;
      cfg_load_q    <= 1'b0;
      at_limit_q    <= '0;
      for (int unsigned ch = 0; ch < NCH; ch++) begin
        state_q[ch]  <= ST_IDLE;
        cnt_q[ch]    <= '0;
        shadow_q[ch] <= (ch == 0) ? PIE_DEF_W : FREE_DEF_W;
        active_q[ch] <= (ch == 0) ? PIE_DEF_W : FREE_DEF_W;
      end
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      dir_q         <= dir_d;
      cfg_pending_q <= cfg_pending_d;
      cfg_load_q    <= cfg_load_d;
      at_limit_q    <= at_limit_d;
      for (int unsigned ch = 0; ch < NCH; ch++) begin
        state_q[ch]  <= state_d[ch];
        cnt_q[ch]    <= cnt_d[ch];
        shadow_q[ch] <= shadow_d[ch];
        active_q[ch] <= active_d[ch];
      end
    end
  end

  assign pieovertwo_len  = active_q[0];
  assign freeprecess_len = active_q[1];
  assign cfg_pending     = cfg_pending_q;
  assign cfg_load        = cfg_load_q;
  assign at_limit        = at_limit_q;

endmodule

// File: tb/tb_pop_timing_config.sv
// Bench for pop_timing_config: three parameterisations share one stimulus stream
// and are checked every cycle against a hold-duration reference model.
module tb_pop_timing_config;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n, tick, ld_in, pp, pm, fp, fm, cycle_end, timer_idle;

  logic [15:0] pie_o  [3];
  logic [15:0] free_o [3];
  logic        pend_o [3];
  logic        load_o [3];
  logic [1:0]  lim_o  [3];

  int n_checks = 0;
  int n_errs   = 0;

  // Instance parameters mirrored for the model
  int p_def [3][2] = '{'{250, 2500}, '{7, 2500}, '{24998, 12}};
  int p_rd  [3]    = '{5000, 3, 3};
  int p_rp  [3]    = '{1000, 2, 2};

  pop_timing_config u_a (
    .clk_2M5(clk), .reset_n(reset_n), .tick_100us(tick), .load_defaults(ld_in),
    .pieovertwo_plus(pp), .pieovertwo_minus(pm), .freeprecess_plus(fp),
    .freeprecess_minus(fm), .cycle_end(cycle_end), .timer_idle(timer_idle),
    .pieovertwo_len(pie_o[0]), .freeprecess_len(free_o[0]), .cfg_pending(pend_o[0]),
    .cfg_load(load_o[0]), .at_limit(lim_o[0]));

  pop_timing_config #(.PIE_DEFAULT(7), .FREE_DEFAULT(2500),
                      .REPEAT_DELAY(3), .REPEAT_PERIOD(2)) u_b (
    .clk_2M5(clk), .reset_n(reset_n), .tick_100us(tick), .load_defaults(ld_in),
    .pieovertwo_plus(pp), .pieovertwo_minus(pm), .freeprecess_plus(fp),
    .freeprecess_minus(fm), .cycle_end(cycle_end), .timer_idle(timer_idle),
    .pieovertwo_len(pie_o[1]), .freeprecess_len(free_o[1]), .cfg_pending(pend_o[1]),
    .cfg_load(load_o[1]), .at_limit(lim_o[1]));

  pop_timing_config #(.PIE_DEFAULT(24998), .FREE_DEFAULT(12),
                      .REPEAT_DELAY(3), .REPEAT_PERIOD(2)) u_c (
    .clk_2M5(clk), .reset_n(reset_n), .tick_100us(tick), .load_defaults(ld_in),
    .pieovertwo_plus(pp), .pieovertwo_minus(pm), .freeprecess_plus(fp),
    .freeprecess_minus(fm), .cycle_end(cycle_end), .timer_idle(timer_idle),
    .pieovertwo_len(pie_o[2]), .freeprecess_len(free_o[2]), .cfg_pending(pend_o[2]),
    .cfg_load(load_o[2]), .at_limit(lim_o[2]));

  // Reference model: shadow/active values, pressed direction, ticks held, blocked
  int         m_sh   [3][2];
  int         m_ac   [3][2];
  int         m_dir  [3][2];
  int         m_hold [3][2];
  bit         m_blk  [3][2];
  bit         m_load [3];
  logic [4:0] m_s1, m_s2;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int step_val(input int v, input int dir);
    if (dir > 0) return (v + 5 > 25000) ? 25000 : v + 5;
    return (v < 10) ? 5 : v - 5;
  endfunction

  function automatic bit at_lim(input int v);
    return (v == 5) || (v == 25000);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      for (int c = 0; c < 2; c++) begin
        m_sh[k][c]   = p_def[k][c];
        m_ac[k][c]   = p_def[k][c];
        m_dir[k][c]  = 0;
        m_hold[k][c] = 0;
        m_blk[k][c]  = 1'b0;
      end
      m_load[k] = 1'b0;
    end
    m_s1 = '0;
    m_s2 = '0;
  endtask

  task automatic chan_update(input int k, input int c, input bit ld, input bit p, input bit m);
    bit pressed, other;
    if (ld) begin
      m_sh[k][c]  = p_def[k][c];
      m_blk[k][c] = 1'b1;
      m_dir[k][c] = 0;
    end else if (tick) begin
      if (m_blk[k][c]) begin
        if (!p && !m) m_blk[k][c] = 1'b0;
      end else if (m_dir[k][c] == 0) begin
        if (p && m) begin
          m_blk[k][c] = 1'b1;
        end else if (p || m) begin
          m_dir[k][c]  = p ? 1 : -1;
          m_hold[k][c] = 0;
          m_sh[k][c]   = step_val(m_sh[k][c], m_dir[k][c]);
        end
      end else begin
        pressed = (m_dir[k][c] > 0) ? p : m;
        other   = (m_dir[k][c] > 0) ? m : p;
        if (!pressed) begin
          m_dir[k][c] = 0;
        end else if (other) begin
          m_blk[k][c] = 1'b1;
          m_dir[k][c] = 0;
        end else begin
          m_hold[k][c]++;
          if (m_hold[k][c] == p_rd[k] ||
              (m_hold[k][c] > p_rd[k] && (m_hold[k][c] - p_rd[k]) % p_rp[k] == 0))
            m_sh[k][c] = step_val(m_sh[k][c], m_dir[k][c]);
        end
      end
    end
  endtask

  // Applied at each rising edge with the inputs that were stable before it
  task automatic model_edge();
    logic [4:0] raw;
    bit         xfer;
    int         nac [2];
    raw = {ld_in, pp, pm, fp, fm};
    for (int k = 0; k < 3; k++) begin
      xfer = ((m_sh[k][0] != m_ac[k][0]) || (m_sh[k][1] != m_ac[k][1])) &&
             (cycle_end || timer_idle);
      for (int c = 0; c < 2; c++) nac[c] = xfer ? m_sh[k][c] : m_ac[k][c];
      chan_update(k, 0, m_s2[4], m_s2[3], m_s2[2]);
      chan_update(k, 1, m_s2[4], m_s2[1], m_s2[0]);
      for (int c = 0; c < 2; c++) m_ac[k][c] = nac[c];
      m_load[k] = xfer;
    end
    m_s2 = m_s1;
    m_s1 = raw;
  endtask

  task automatic check_all();
    bit pend;
    for (int k = 0; k < 3; k++) begin
      pend = (m_sh[k][0] != m_ac[k][0]) || (m_sh[k][1] != m_ac[k][1]);
      check_eq($sformatf("pie_len[%0d]", k),  32'(pie_o[k]),  32'(m_ac[k][0]));
      check_eq($sformatf("free_len[%0d]", k), 32'(free_o[k]), 32'(m_ac[k][1]));
      check_eq($sformatf("pending[%0d]", k),  32'(pend_o[k]), 32'(pend));
      check_eq($sformatf("load[%0d]", k),     32'(load_o[k]), 32'(m_load[k]));
      check_eq($sformatf("at_limit[%0d]", k), 32'(lim_o[k]),
               32'({at_lim(m_sh[k][1]), at_lim(m_sh[k][0])}));
    end
  endtask

  task automatic clk_cycle();
    @(posedge clk);
    if (reset_n) model_edge();
    @(negedge clk);
    check_all();
  endtask

  // Each tick follows three quiet cycles so button changes are synchronized first
  task automatic do_ticks(input int n);
    repeat (n) begin
      tick = 1'b0;
      repeat (3) clk_cycle();
      tick = 1'b1;
      clk_cycle();
      tick = 1'b0;
    end
  endtask

  task automatic press_pie_plus();
    pp = 1'b1; do_ticks(1);
    pp = 1'b0; do_ticks(1);
  endtask

  task automatic pulse_ce(output int loads);
    cycle_end = 1'b1;
    clk_cycle();
    cycle_end = 1'b0;
    loads = int'(load_o[0]);
    repeat (4) begin
      clk_cycle();
      loads += int'(load_o[0]);
    end
  endtask

  initial begin
    int loads;
    reset_n = 1'b0; tick = 1'b0; ld_in = 1'b0; pp = 1'b0; pm = 1'b0;
    fp = 1'b0; fm = 1'b0; cycle_end = 1'b0; timer_idle = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all();
    check_eq("reset_pie", 32'(pie_o[0]), 32'd250);
    check_eq("reset_free", 32'(free_o[0]), 32'd2500);
    check_eq("reset_pending", 32'(pend_o[0]), 32'd0);
    check_eq("reset_at_limit", 32'(lim_o[0]), 32'd0);
    reset_n = 1'b1;
    repeat (2) clk_cycle();

    // Short press: shadow moves, active waits for a boundary
    press_pie_plus();
    check_eq("short_press_active", 32'(pie_o[0]), 32'd250);
    check_eq("short_press_pending", 32'(pend_o[0]), 32'd1);
    check_eq("max_sat_limit", 32'(lim_o[2]), 32'd1);
    repeat (9) press_pie_plus();
    check_eq("edit300_active", 32'(pie_o[0]), 32'd250);
    check_eq("max_sat_hold", 32'(lim_o[2]), 32'd1);

    // Defaults restore the shadow; boundary then loads nothing
    ld_in = 1'b1; repeat (5) clk_cycle(); ld_in = 1'b0;
    do_ticks(2);
    check_eq("ld_pending", 32'(pend_o[0]), 32'd0);
    pulse_ce(loads);
    check_eq("ld_noload", 32'(loads), 32'd0);
    check_eq("ld_active", 32'(pie_o[0]), 32'd250);

    press_pie_plus();
    pulse_ce(loads);
    check_eq("ce_active", 32'(pie_o[0]), 32'd255);
    check_eq("ce_one_load", 32'(loads), 32'd1);
    check_eq("max_active", 32'(pie_o[2]), 32'd25000);

    // Minimum saturation from 7
    ld_in = 1'b1; repeat (5) clk_cycle(); ld_in = 1'b0;
    do_ticks(2);
    pm = 1'b1; do_ticks(1); pm = 1'b0; do_ticks(1);
    check_eq("min_limit", 32'(lim_o[1]), 32'd1);
    pm = 1'b1; do_ticks(1); pm = 1'b0; do_ticks(1);
    timer_idle = 1'b1;
    repeat (3) clk_cycle();
    check_eq("min_active", 32'(pie_o[1]), 32'd5);
    check_eq("min_limit_hold", 32'(lim_o[1]), 32'd1);
    check_eq("minus_active", 32'(pie_o[0]), 32'd240);

    // Both buttons block until both are released
    pp = 1'b1; pm = 1'b1; do_ticks(2);
    pm = 1'b0; do_ticks(3);
    check_eq("blocked_one_released", 32'(pie_o[0]), 32'd240);
    pp = 1'b0; do_ticks(1);
    check_eq("blocked_released", 32'(pie_o[0]), 32'd240);
    press_pie_plus();
    check_eq("unblocked_step", 32'(pie_o[0]), 32'd245);

    // Auto-repeat with delay 3 / period 2
    fm = 1'b1; do_ticks(9);
    fm = 1'b0; do_ticks(1);
    repeat (3) clk_cycle();
    check_eq("repeat_free", 32'(free_o[1]), 32'd2480);
    check_eq("repeat_free_a", 32'(free_o[0]), 32'd2495);
    check_eq("repeat_min_limit", 32'(lim_o[2]), 32'd2);

    // Step and transfer on the same edge
    timer_idle = 1'b0;
    press_pie_plus();
    pp = 1'b1;
    repeat (3) clk_cycle();
    tick = 1'b1; cycle_end = 1'b1;
    clk_cycle();
    tick = 1'b0; cycle_end = 1'b0;
    check_eq("coincide_active", 32'(pie_o[0]), 32'd250);
    check_eq("coincide_pending", 32'(pend_o[0]), 32'd1);
    pp = 1'b0; do_ticks(1);
    pulse_ce(loads);
    check_eq("coincide_final", 32'(pie_o[0]), 32'd255);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(39) == 0) pp = ~pp;
      if ($urandom_range(39) == 0) pm = ~pm;
      if ($urandom_range(39) == 0) fp = ~fp;
      if ($urandom_range(39) == 0) fm = ~fm;
      tick      = ($urandom_range(3) == 0);
      cycle_end = ($urandom_range(15) == 0);
      if ($urandom_range(99) == 0) timer_idle = ~timer_idle;
      if (ld_in) begin
        if ($urandom_range(3) == 0) ld_in = 1'b0;
      end else if ($urandom_range(599) == 0) begin
        ld_in = 1'b1;
      end
      clk_cycle();
    end
    tick = 1'b0; cycle_end = 1'b0; ld_in = 1'b0;

    // Asynchronous reset in the middle of a hold
    pp = 1'b1; pm = 1'b0; fp = 1'b0; fm = 1'b0;
    do_ticks(3);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_all();
    check_eq("midreset_pie", 32'(pie_o[0]), 32'd250);
    check_eq("midreset_pending", 32'(pend_o[0]), 32'd0);
    pp = 1'b0; timer_idle = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) clk_cycle();

    // Full-length hold on the default instance with a tick every cycle
    pp = 1'b1; tick = 1'b1; timer_idle = 1'b1;
    repeat (7100) clk_cycle();
    pp = 1'b0;
    repeat (6) clk_cycle();
    tick = 1'b0;
    repeat (2) clk_cycle();
    check_eq("long_hold_pie", 32'(pie_o[0]), 32'd270);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
